mac_dot_pipe: RTL and testbench
===============================

// Module: mac_dot_pipe
// PURPOSE
//  Parametrised successor to the single-product MAC: LANES signed/unsigned
//  BW-bit products summed with a PSUM_BW partial sum in a 2-stage pipeline.
//  Valid/ready handshakes on input and output; optional internal accumulation
//  and saturation. Sits between the L0/IFIFO feed and the OFIFO/psum path.
// PARAMETERS
//  BW       4   activation/weight width per lane
//  PSUM_BW  16  partial-sum / output width
//  LANES    4   products per dot step (>=1)
//  SAT_EN   1   1: clamp to PSUM_BW signed range; 0: two's-complement wrap
// PORTS
//  clk          in   1            rising-edge clock
//  reset_n      in   1            async active-low reset
//  in_valid     in   1            a_vec/b_vec/c_in/mode valid
//  in_ready     out  1            stage 1 can accept this cycle
//  a_vec        in   LANES*BW     activations, lane i = [i*BW +: BW]
//  b_vec        in   LANES*BW     weights, always signed
//  c_in         in   PSUM_BW      signed external addend
//  act_unsigned in   1            1: activations zero-extended; 0: signed
//  acc_mode     in   1            1: addend = previous result; 0: c_in
//  clear        in   1            sync flush + zero accumulator
//  out_valid    out  1            out/sat_flag valid
//  out_ready    in   1            consumer accepts
//  out          out  PSUM_BW      signed result
//  sat_flag     out  1            result was clamped (SAT_EN=1 only)
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  Reset: out_valid=0, out=0, sat_flag=0, internal s1_valid=0, all regs 0.
//  Stage 1 (on in_valid&&in_ready): register LANES products, each
//   (BW+1)x BW signed -> 2*BW+1 bits; a extended per act_unsigned.
//   Also register c_in, acc_mode.
//  Stage 2 (when s1_valid and stage 2 free): sum = adder tree of products
//   (width 2*BW+1+clog2(LANES)) sign-extended to PSUM_BW+clog2(LANES)+2,
//   plus addend (acc_mode ? out register : c_in). Result saturated to
//   [-2^(PSUM_BW-1), 2^(PSUM_BW-1)-1] if SAT_EN, else low PSUM_BW bits.
//  Stage 2 free = !out_valid || out_ready. in_ready = !s1_valid || s2 free.
//   Both stages advance in the same cycle when full and out_ready=1:
//   full throughput, latency 2 cycles input handshake -> out_valid.
//  Backpressure: out_ready=0 holds out/sat_flag/out_valid stable; stage 1
//   holds; in_ready drops once both stages full. No data lost/duplicated.
//  Accumulation: out register is the accumulator; acc_mode uses the value
//   it holds when the item enters stage 2 (back-to-back acc items chain
//   correctly, no bubble). Consuming a result does not zero it.
//  clear: highest priority; next edge s1_valid=0, out_valid=0, out=0,
//   sat_flag=0; in_ready=0 during clear, input ignored.
//  Reset mid-operation: all in-flight items dropped, outputs as reset.
//  sat_flag is per-result, registered with out; 0 whenever SAT_EN=0.
// STRUCTURE
//  Shared package mac_pkg: localparams for psum_bw default, LANES default,
//   function clog2, function sat_trunc(sum, PSUM_BW).
//  One sub-module: mac_lane_mult (per-lane signed/unsigned product),
//   generate-instantiated LANES times; tree + control in this file.
// TESTING
//  1 Reset: reset_n=0 mid-stream -> out_valid=0, out=0, in_ready=1 next cyc.
//  2 Dot: LANES=4, a={1,2,3,-1}, b={2,2,2,2}, c_in=10, signed -> out=20
//    two cycles after accept; act_unsigned=1 (a lane3=15) -> out=52.
//  3 Accumulate: clear, then 3 back-to-back acc_mode=1 items each sum=8
//    -> results 8,16,24 on consecutive cycles, out_ready=1.
//  4 Saturation: c_in=32760, products sum=56, SAT_EN=1 -> out=32767,
//    sat_flag=1; SAT_EN=0 -> out=-32720, sat_flag=0.
//  5 Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0
//    after 2 accepts, out stable; release -> results in order, none lost.
//  6 clear with in_valid=1 and both stages full -> nothing emitted, out=0.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared defaults and helpers for the dot-product MAC pipeline.
package mac_pkg;

  localparam int BW_DEF      = 4;
  localparam int PSUM_BW_DEF = 16;
  localparam int LANES_DEF   = 4;

  // Ceiling log2 for sizing the adder-tree growth; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Clamp a wide signed sum into the signed psum_bw range.
  function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] sum,
                                                   input int               psum_bw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (psum_bw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (psum_bw - 1));
    if (sum > hi)      return hi;
    else if (sum < lo) return lo;
    return sum;
  endfunction

endpackage

// File: rtl/mac_lane_mult.sv
// One lane product: activation (signed or zero-extended) times signed weight.
module mac_lane_mult #(
  parameter int BW = 4
) (
  input  logic [BW-1:0]   i_a,
  input  logic [BW-1:0]   i_b,
  input  logic            i_act_unsigned,
  output logic [2*BW:0]   o_prod
);

  logic signed [BW:0]   w_a_ext;
  logic signed [BW-1:0] w_b;
  logic signed [2*BW:0] w_prod;

  // Activation gets one extra bit so unsigned values stay positive in a signed multiply.
  assign w_a_ext = i_act_unsigned ? $signed({1'b0, i_a}) : $signed({i_a[BW-1], i_a});
  assign w_b     = $signed(i_b);
  assign w_prod  = (2*BW+1)'(w_a_ext) * (2*BW+1)'(w_b);
  assign o_prod  = w_prod;

endmodule

// File: rtl/mac_dot_pipe.sv
// Two-stage LANES-wide dot product with addend, accumulation and saturation.
// Stage 1 registers lane products; stage 2 (the out register) sums and clamps.
module mac_dot_pipe
  import mac_pkg::*;
#(
  parameter int BW      = BW_DEF,
  parameter int PSUM_BW = PSUM_BW_DEF,
  parameter int LANES   = LANES_DEF,
  parameter int SAT_EN  = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*BW-1:0]   a_vec,
  input  logic [LANES*BW-1:0]   b_vec,
  input  logic [PSUM_BW-1:0]    c_in,
  input  logic                  act_unsigned,
  input  logic                  acc_mode,
  input  logic                  clear,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PSUM_BW-1:0]    out,
  output logic                  sat_flag
);

  localparam int PW = 2*BW + 1;           // lane product width
  localparam int LG = clog2(LANES);
  localparam int TW = PW + LG;            // adder tree width
  localparam int EW = PSUM_BW + LG + 2;   // final sum width before clamp

  logic [LANES-1:0][PW-1:0]   w_prod;
  logic [LANES-1:0][PW-1:0]   r_prod;
  logic signed [PSUM_BW-1:0]  r_c;
  logic                       r_acc;
  logic signed [PSUM_BW-1:0]  r_out;
  logic                       r_sat;
  logic [2:1]                 r_vld_pipe;  // [1] stage-1 full, [2] result held

  logic                       w_s2_free;
  logic                       w_s2_adv;
  logic                       w_in_fire;
  logic signed [TW-1:0]       w_tree;
  logic signed [PSUM_BW-1:0]  w_addend;
  logic signed [EW-1:0]       w_sum;
  logic signed [63:0]         w_sum64;
  logic signed [63:0]         w_sat;
  logic [PSUM_BW-1:0]         w_res;
  logic                       w_flag;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mac_lane_mult #(.BW(BW)) u_lane (
      .i_a            (a_vec[g*BW +: BW]),
      .i_b            (b_vec[g*BW +: BW]),
      .i_act_unsigned (act_unsigned),
      .o_prod         (w_prod[g])
    );
  end

  // Handshake: stage 2 drains when its result is taken; clear blocks intake.
  assign w_s2_free = !r_vld_pipe[2] || out_ready;
  assign w_s2_adv  = r_vld_pipe[1] && w_s2_free;
  assign in_ready  = !clear && (!r_vld_pipe[1] || w_s2_free);
  assign w_in_fire = in_valid && in_ready;

  // Sum the registered lane products, sign-extended to the tree width.
  always_comb begin
    w_tree = '0;
    for (int i = 0; i < LANES; i++) w_tree = w_tree + TW'($signed(r_prod[i]));
  end

  // Accumulation reads the out register as it stands when the item enters stage 2.
  assign w_addend = r_acc ? r_out : r_c;
  assign w_sum    = EW'(w_tree) + EW'(w_addend);
  assign w_sum64  = 64'(w_sum);
  assign w_sat    = sat_trunc(w_sum64, PSUM_BW);

  // Pick clamped or wrapped result; the flag only exists when clamping.
  always_comb begin
    if (SAT_EN != 0) begin
      w_res  = w_sat[PSUM_BW-1:0];
      w_flag = (w_sat != w_sum64);
    end else begin
      w_res  = w_sum[PSUM_BW-1:0];
      w_flag = 1'b0;
    end
  end

  // Pipeline registers; clear flushes both stages and zeroes the accumulator.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld_pipe <= '0;
      r_prod     <= '0;
      r_c        <= '0;
      r_acc      <= 1'b0;
      r_out      <= '0;
      r_sat      <= 1'b0;
    end else if (clear) begin
      r_vld_pipe <= '0;
      r_out      <= '0;
      r_sat      <= 1'b0;
    end else begin
      if (w_in_fire) begin
        r_vld_pipe[1] <= 1'b1;
        r_prod        <= w_prod;
        r_c           <= c_in;
        r_acc         <= acc_mode;
      end else if (w_s2_adv) begin
        r_vld_pipe[1] <= 1'b0;
      end
      if (w_s2_adv) begin
        r_vld_pipe[2] <= 1'b1;
        r_out         <= w_res;
        r_sat         <= w_flag;
      end else if (out_ready) begin
        r_vld_pipe[2] <= 1'b0;
      end
    end
  end

  assign out_valid = r_vld_pipe[2];
  assign out       = r_out;
  assign sat_flag  = r_sat;

endmodule

// File: tb/tb_mac_dot_pipe.sv
// Bench for mac_dot_pipe: one saturating and one wrapping instance share stimulus;
// an arithmetic reference model predicts every result in acceptance order.
module tb_mac_dot_pipe;

  logic               clk;
  logic               reset_n;
  logic               in_valid;
  logic               in_ready1, in_ready0;
  logic [15:0]        a_vec, b_vec;
  logic signed [15:0] c_in;
  logic               act_unsigned, acc_mode, clear;
  logic               out_valid1, out_valid0;
  logic               out_ready;
  logic signed [15:0] out1, out0;
  logic               sat1, sat0;

  mac_dot_pipe #(.BW(4), .PSUM_BW(16), .LANES(4), .SAT_EN(1)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready1),
    .a_vec(a_vec), .b_vec(b_vec), .c_in(c_in), .act_unsigned(act_unsigned),
    .acc_mode(acc_mode), .clear(clear), .out_valid(out_valid1),
    .out_ready(out_ready), .out(out1), .sat_flag(sat1));

  mac_dot_pipe #(.BW(4), .PSUM_BW(16), .LANES(4), .SAT_EN(0)) dut_w (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready0),
    .a_vec(a_vec), .b_vec(b_vec), .c_in(c_in), .act_unsigned(act_unsigned),
    .acc_mode(acc_mode), .clear(clear), .out_valid(out_valid0),
    .out_ready(out_ready), .out(out0), .sat_flag(sat0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { longint o1; bit f1; longint o0; } exp_t;
  exp_t   q[$];
  longint acc1, acc0;
  int     errors, checks, n_push, n_pop;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Plain dot product of four 4-bit lanes.
  function automatic longint dot(input logic [15:0] a, input logic [15:0] b, input bit au);
    longint s, av, bv;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      av = au ? longint'(a[i*4 +: 4]) : longint'($signed(a[i*4 +: 4]));
      bv = longint'($signed(b[i*4 +: 4]));
      s += av * bv;
    end
    return s;
  endfunction

  // One cycle: observe handshakes at the falling edge, then step past the rising edge.
  task automatic tick();
    exp_t   e;
    longint d, s1, s0, w;
    @(negedge clk);
    if (!reset_n || clear) begin
      q.delete(); acc1 = 0; acc0 = 0;
    end else begin
      if (out_valid1 && out_ready) begin
        chk("valid_pair", out_valid0, 1);
        chk("out_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("out_sat", out1, e.o1);
          chk("flag_sat", sat1, e.f1);
          chk("out_wrap", out0, e.o0);
          chk("flag_wrap", sat0, 0);
          n_pop++;
        end
      end
      if (in_valid && in_ready1) begin
        d  = dot(a_vec, b_vec, act_unsigned);
        s1 = d + (acc_mode ? acc1 : longint'(c_in));
        s0 = d + (acc_mode ? acc0 : longint'(c_in));
        e.o1 = (s1 > 32767) ? 32767 : (s1 < -32768) ? -32768 : s1;
        e.f1 = (s1 > 32767) || (s1 < -32768);
        w = s0 & 64'hFFFF;
        if (w > 32767) w -= 65536;
        e.o0 = w;
        acc1 = e.o1; acc0 = e.o0;
        q.push_back(e);
        n_push++;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int n0, p0;
    longint hold;
    errors = 0; checks = 0; n_push = 0; n_pop = 0; acc1 = 0; acc0 = 0;
    reset_n = 1'b0; in_valid = 1'b0; a_vec = '0; b_vec = '0; c_in = '0;
    act_unsigned = 1'b0; acc_mode = 1'b0; clear = 1'b0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_out_valid", out_valid1, 0);
    chk("rst_out", out1, 0);
    chk("rst_sat", sat1, 0);
    chk("rst_in_ready", in_ready1, 1);
    reset_n = 1'b1;
    tick();

    // Signed dot: 2+4+6-2 + 10 = 20, two cycles after acceptance.
    a_vec = 16'hF321; b_vec = 16'h2222; c_in = 16'sd10; in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    chk("dot_lat1", out_valid1, 0);
    tick();
    chk("dot_lat2", out_valid1, 1);
    chk("dot_signed", out1, 20);
    // Unsigned activations: lane 3 becomes 15 -> 52.
    act_unsigned = 1'b1; in_valid = 1'b1;
    tick(); in_valid = 1'b0; act_unsigned = 1'b0;
    tick();
    chk("dot_unsigned", out1, 52);
    tick();

    // Accumulate three items of 8 after clear.
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clr_out", out1, 0);
    a_vec = 16'h1111; b_vec = 16'h2222; acc_mode = 1'b1; in_valid = 1'b1;
    c_in = 16'($urandom);
    tick(); c_in = 16'($urandom);
    tick(); chk("acc_1", out1, 8);
    tick(); chk("acc_2", out1, 16); in_valid = 1'b0;
    tick(); chk("acc_3", out1, 24); chk("acc_3v", out_valid1, 1);
    acc_mode = 1'b0;
    tick();

    // Saturation versus wrap: 32760 + 56.
    a_vec = 16'h7777; b_vec = 16'h2222; c_in = 16'sd32760; in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    tick();
    chk("sat_out", out1, 32767);
    chk("sat_flag", sat1, 1);
    chk("wrap_out", out0, -32720);
    chk("wrap_flag", sat0, 0);
    tick(); tick();

    // Backpressure: only two items fit, the held result stays put.
    out_ready = 1'b0; in_valid = 1'b1; n0 = n_push;
    for (int k = 0; k < 5; k++) begin
      a_vec = 16'($urandom); b_vec = 16'($urandom); c_in = 16'($urandom);
      act_unsigned = 1'($urandom);
      tick();
    end
    chk("bp_in_ready", in_ready1, 0);
    chk("bp_accepts", n_push - n0, 2);
    hold = (q.size() != 0) ? q[0].o1 : -99999;
    chk("bp_hold", out1, hold);
    chk("bp_valid", out_valid1, 1);
    p0 = n_pop; out_ready = 1'b1; in_valid = 1'b0;
    for (int k = 0; k < 10 && q.size() > 0; k++) tick();
    chk("bp_drained", n_pop - p0, 2);
    act_unsigned = 1'b0;

    // Clear while both stages hold data.
    out_ready = 1'b0; in_valid = 1'b1; a_vec = 16'h1234; b_vec = 16'h4321; c_in = 16'sd5;
    tick(); tick(); tick();
    chk("full_in_ready", in_ready1, 0);
    clear = 1'b1;
    #1 chk("clear_in_ready", in_ready1, 0);
    tick();
    clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("clr_no_out", out_valid1, 0);
      chk("clr_zero", out1, 0);
    end

    // Reset in the middle of a stream drops everything in flight.
    in_valid = 1'b1; a_vec = 16'h5555; b_vec = 16'h3333;
    tick(); tick();
    reset_n = 1'b0;
    #1;
    q.delete(); acc1 = 0; acc0 = 0;
    chk("mid_rst_valid", out_valid1, 0);
    chk("mid_rst_out", out1, 0);
    tick();
    chk("mid_rst_in_ready", in_ready1, 1);
    in_valid = 1'b0; reset_n = 1'b1;
    tick();
    chk("post_rst_valid", out_valid1, 0);

    // Randomised traffic with backpressure, accumulation and rare clears.
    for (int k = 0; k < 400; k++) begin
      in_valid     = ($urandom % 4) != 0;
      out_ready    = ($urandom % 4) != 0;
      a_vec        = 16'($urandom);
      b_vec        = 16'($urandom);
      c_in         = 16'($urandom);
      act_unsigned = 1'($urandom);
      acc_mode     = ($urandom % 2) == 0;
      clear        = ($urandom % 64) == 0;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1; clear = 1'b0;
    for (int k = 0; k < 10 && q.size() > 0; k++) tick();
    chk("rand_drained", q.size(), 0);
    chk("rand_ready_pair", in_ready0, in_ready1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
